instr_fetch_decode: RTL

- Fetch stage plus instruction register for the 16-bit CPU.
- Holds the PC and requests instruction words from instruction memory over a req/ack handshake.
- Latches each returned word and splits it into opcode, rd, immHigh and immLow fields.
- immHigh/immLow feed the downstream immediate sign extender directly; opcode/rd go to the decoder and register file.

---
 rtl/instr_fetch_decode.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Fetch stage and instruction register for the 16-bit CPU: PC, req/ack instruction
// memory handshake, branch redirect with squash, and field split of the held word.
module instr_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        immHigh,
  output logic [3:0]        immLow,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  logic [ADDR_W-1:0] pcOut, pcOutNext;
  logic [15:0]       instr, instrNext;
  logic              memReq, memReqNext;
  logic              decValid, decValidNext;
  logic              haltedQ, haltedNext;
  logic              squash, squashNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      memAddr  <= RESET_PC;
      pcOut    <= '0;
      instr    <= '0;
      memReq   <= 1'b0;
      decValid <= 1'b0;
      haltedQ  <= 1'b0;
      squash   <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      memAddr  <= memAddrNext;
      pcOut    <= pcOutNext;
      instr    <= instrNext;
      memReq   <= memReqNext;
      decValid <= decValidNext;
      haltedQ  <= haltedNext;
      squash   <= squashNext;
    end
  end

  // memAddr tracks pc except while a redirected request is still outstanding.
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    memAddrNext  = memAddr;
    pcOutNext    = pcOut;
    instrNext    = instr;
    memReqNext   = memReq;
    decValidNext = decValid;
    haltedNext   = haltedQ;
    squashNext   = squash;
    case (state)
      FETCH: begin
        if (!memReq) begin
          memReqNext = 1'b1;
          if (branch_taken) begin
            pcNext      = branch_target;
            memAddrNext = branch_target;
          end else begin
            memAddrNext = pc;
          end
        end else if (mem_ack) begin
          if (branch_taken) begin
            pcNext      = branch_target;
            memAddrNext = branch_target;
            squashNext  = 1'b0;
          end else if (squash) begin
            squashNext  = 1'b0;
            memAddrNext = pc;
          end else begin
            instrNext    = mem_rdata;
            pcOutNext    = pc;
            pcNext       = pc + PC_INC;
            memAddrNext  = pc + PC_INC;
            memReqNext   = 1'b0;
            decValidNext = 1'b1;
            stateNext    = HOLD;
          end
        end else if (branch_taken) begin
          pcNext     = branch_target;
          squashNext = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          decValidNext = 1'b0;
          pcNext       = branch_target;
          memAddrNext  = branch_target;
          memReqNext   = 1'b1;
          stateNext    = FETCH;
        end else if (dec_ready) begin
          decValidNext = 1'b0;
          if (instr[15:12] == HALT_OP) begin
            haltedNext = 1'b1;
            stateNext  = HALTED;
          end else begin
            memReqNext  = 1'b1;
            memAddrNext = pc;
            stateNext   = FETCH;
          end
        end
      end
      HALTED: begin
        memReqNext   = 1'b0;
        decValidNext = 1'b0;
      end
      default: stateNext = FETCH;
    endcase
  end

  assign mem_req   = memReq;
  assign mem_addr  = memAddr;
  assign dec_valid = decValid;
  assign pc_out    = pcOut;
  assign halted    = haltedQ;
  assign opcode    = instr[15:12];
  assign rd        = instr[11:8];
  assign immHigh   = instr[7:4];
  assign immLow    = instr[3:0];

endmodule
